// File: rtl/tx_write_arbiter_if.sv
// Producer-side and transmitter-FIFO-side signals of tx_write_arbiter.
// The arbiter connects through the slave modport; producers and FIFO model through master.
interface tx_write_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]      req_valid_i;
   logic [N_REQ-1:0][7:0] req_data_i;
   logic [N_REQ-1:0]      req_ready_o;
   logic [7:0]            data_tx_o;
   logic                  tx_fifo_write_o;
   logic                  tx_fifo_full_i;
   logic                  tx_fifo_empty_i;
   logic                  tx_idle_i;

   modport slave (
      input  req_valid_i, req_data_i, tx_fifo_full_i, tx_fifo_empty_i, tx_idle_i,
      output req_ready_o, data_tx_o, tx_fifo_write_o
   );

   modport master (
      output req_valid_i, req_data_i, tx_fifo_full_i, tx_fifo_empty_i, tx_idle_i,
      input  req_ready_o, data_tx_o, tx_fifo_write_o
   );
endinterface

// File: rtl/tx_write_arbiter.sv
// Shares the UART transmitter FIFO write port among N_REQ producers and sequences format reconfiguration.
// Define TX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module tx_write_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   tx_write_arbiter_if.slave   bus,
   input  logic                cfg_req_i,
   input  logic [1:0]          cfg_data_width_i,
   input  logic [1:0]          cfg_stop_bits_i,
   input  logic [1:0]          cfg_parity_i,
   output logic                config_req_mst_o,
   input  logic                req_done_i,
   output logic [1:0]          data_width_o,
   output logic [1:0]          stop_bits_number_o,
   output logic [1:0]          parity_mode_o,
   output logic                cfg_done_o,
   output logic                busy_cfg_o
);

   typedef enum logic [1:0] {
      ARBITRATE,
      DRAIN,
      CONFIG
   } state_t;

   state_t               state;
   logic [1:0]           shadow_width;
   logic [1:0]           shadow_stop;
   logic [1:0]           shadow_parity;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     scan_idx;
   logic                 grant_found;
   logic                 accept;
   logic [N_REQ-1:0]     ready_vec;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = PTR_W'((32'(rr_ptr) + k) % 32'(N_REQ));
         if (!grant_found && bus.req_valid_i[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Reset gating keeps the combinational handshake outputs at their reset values while rst_n_i is low.
   assign accept = rst_n_i && (state == ARBITRATE) && !cfg_req_i
                   && !bus.tx_fifo_full_i && grant_found;

   always_comb begin
      ready_vec = '0;
      if (accept) ready_vec[grant_idx] = 1'b1;
   end

   assign bus.req_ready_o     = ready_vec;
   assign bus.tx_fifo_write_o = accept;
   assign bus.data_tx_o       = accept ? bus.req_data_i[grant_idx] : '0;
   assign busy_cfg_o          = (state != ARBITRATE);

`ifdef TX_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [PTR_W-1:0] ptr_next;

   assign ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    rr_ptr <= '0;
      else if (accept) rr_ptr <= ptr_next;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state              <= ARBITRATE;
         shadow_width       <= 2'b11;
         shadow_stop        <= '0;
         shadow_parity      <= '0;
         data_width_o       <= 2'b11;
         stop_bits_number_o <= '0;
         parity_mode_o      <= '0;
         config_req_mst_o   <= 1'b0;
         cfg_done_o         <= 1'b0;
      end else begin
         cfg_done_o <= 1'b0;
         case (state)
            ARBITRATE: begin
               if (cfg_req_i) begin
                  shadow_width  <= cfg_data_width_i;
                  shadow_stop   <= cfg_stop_bits_i;
                  shadow_parity <= cfg_parity_i;
                  state         <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.tx_fifo_empty_i && bus.tx_idle_i) begin
                  data_width_o       <= shadow_width;
                  stop_bits_number_o <= shadow_stop;
                  parity_mode_o      <= shadow_parity;
                  config_req_mst_o   <= 1'b1;
                  state              <= CONFIG;
               end
            end
            CONFIG: begin
               if (req_done_i) begin
                  config_req_mst_o <= 1'b0;
                  cfg_done_o       <= 1'b1;
                  state            <= ARBITRATE;
               end
            end
            default: state <= ARBITRATE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_write_arbiter.sv
// Bench for tx_write_arbiter: directed vector table, hand-written reconfiguration/reset
// sequences and a randomized run checked against a behavioural model.
module tb_tx_write_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_req;
   logic [1:0] cfg_w, cfg_s, cfg_p;
   logic       mst, req_done, cfg_done, busy;
   logic [1:0] fmt_w, fmt_s, fmt_p;

   always #5 clk = ~clk;

   tx_write_arbiter_if #(.N_REQ(N)) bus ();

   tx_write_arbiter #(.N_REQ(N)) dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .bus                (bus),
      .cfg_req_i          (cfg_req),
      .cfg_data_width_i   (cfg_w),
      .cfg_stop_bits_i    (cfg_s),
      .cfg_parity_i       (cfg_p),
      .config_req_mst_o   (mst),
      .req_done_i         (req_done),
      .data_width_o       (fmt_w),
      .stop_bits_number_o (fmt_s),
      .parity_mode_o      (fmt_p),
      .cfg_done_o         (cfg_done),
      .busy_cfg_o         (busy)
   );

   typedef struct packed {
      logic [N-1:0] ready;
      logic         write;
      logic [7:0]   data;
      logic         mst;
      logic         done;
      logic         busy;
      logic [1:0]   w;
      logic [1:0]   s;
      logic [1:0]   p;
   } obs_t;

   typedef struct {
      logic [N-1:0] valid;
      logic         full;
      logic [N-1:0] exp_ready;
      logic         exp_write;
      logic [7:0]   exp_data;
   } vec_t;

   int checks = 0;
   int passed = 0;

   function automatic obs_t mk(logic [N-1:0] r, logic wr, logic [7:0] d, logic m, logic dn,
                               logic b, logic [1:0] w, logic [1:0] s, logic [1:0] p);
      obs_t o;
      o.ready = r; o.write = wr; o.data = d; o.mst = m; o.done = dn; o.busy = b;
      o.w = w; o.s = s; o.p = p;
      return o;
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t act;
      act = mk(bus.req_ready_o, bus.tx_fifo_write_o, bus.data_tx_o, mst, cfg_done, busy,
               fmt_w, fmt_s, fmt_p);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got ready=%b wr=%b data=%h mst=%b done=%b busy=%b fmt=%b/%b/%b, expected ready=%b wr=%b data=%h mst=%b done=%b busy=%b fmt=%b/%b/%b",
                    name, act.ready, act.write, act.data, act.mst, act.done, act.busy,
                    act.w, act.s, act.p, exp.ready, exp.write, exp.data, exp.mst,
                    exp.done, exp.busy, exp.w, exp.s, exp.p);
   endtask

   // Advance to just after the next rising edge, apply inputs, then wait for the sampling point.
   task automatic cyc(input logic [N-1:0] v, input logic full, input logic empty,
                      input logic idle, input logic cfg, input logic done);
      @(posedge clk);
      #1;
      bus.req_valid_i     = v;
      bus.tx_fifo_full_i  = full;
      bus.tx_fifo_empty_i = empty;
      bus.tx_idle_i       = idle;
      cfg_req             = cfg;
      req_done            = done;
      @(negedge clk);
   endtask

   task automatic set_fixed_data();
      for (int i = 0; i < N; i++) bus.req_data_i[IW'(i)] = 8'hA0 + 8'(i);
   endtask

   // ---------------- behavioural reference model ----------------
   localparam int P_ARB = 0, P_DRAIN = 1, P_CFG = 2;
   int         m_ptr, m_phase;
   logic       m_mst, m_done;
   logic [1:0] m_w, m_s, m_p, sh_w, sh_s, sh_p;

   task automatic model_reset();
      m_ptr = 0; m_phase = P_ARB; m_mst = 1'b0; m_done = 1'b0;
      m_w = 2'b11; m_s = 2'b00; m_p = 2'b00;
   endtask

   task automatic model_eval(output obs_t e, output int acc);
      e = mk('0, 1'b0, 8'h00, m_mst, m_done, m_phase != P_ARB, m_w, m_s, m_p);
      acc = -1;
      if (m_phase == P_ARB && !cfg_req && !bus.tx_fifo_full_i)
         for (int k = 0; k < N; k++)
            if (acc < 0 && bus.req_valid_i[IW'((m_ptr + k) % N)]) acc = (m_ptr + k) % N;
      if (acc >= 0) begin
         e.ready[IW'(acc)] = 1'b1;
         e.write = 1'b1;
         e.data  = bus.req_data_i[IW'(acc)];
      end
   endtask

   task automatic model_advance(input int acc);
      m_done = 1'b0;
`ifndef TX_ARB_FIXED_PRIO_EN
      if (acc >= 0) m_ptr = (acc + 1) % N;
`endif
      if (m_phase == P_ARB) begin
         if (cfg_req) begin
            m_phase = P_DRAIN; sh_w = cfg_w; sh_s = cfg_s; sh_p = cfg_p;
         end
      end else if (m_phase == P_DRAIN) begin
         if (bus.tx_fifo_empty_i && bus.tx_idle_i) begin
            m_phase = P_CFG; m_mst = 1'b1; m_w = sh_w; m_s = sh_s; m_p = sh_p;
         end
      end else if (req_done) begin
         m_phase = P_ARB; m_mst = 1'b0; m_done = 1'b1;
      end
   endtask

   vec_t          vt[16];
   logic [N-1:0]  pend;
   logic [7:0]    pdata[N];
   obs_t          e;
   int            acc;
   logic [N-1:0]  ready_after_cfg;
   logic [7:0]    data_after_cfg;
   logic [N-1:0]  ready_second;
   logic [7:0]    data_second;

   initial begin
`ifdef TX_ARB_FIXED_PRIO_EN
      vt[0]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[1]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[2]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[3]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA1};
      for (int i = 4; i < 9; i++) vt[i] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00};
      vt[9]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0};
      vt[10] = '{4'b1110, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[11] = '{4'b1100, 1'b0, 4'b0100, 1'b1, 8'hA2};
      vt[12] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 8'hA3};
      vt[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      vt[14] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[15] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0};
      ready_after_cfg = 4'b0001; data_after_cfg = 8'hA0;
      ready_second    = 4'b0001; data_second    = 8'hA0;
`else
      vt[0]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 8'hA0};
      vt[1]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 8'hA2};
      vt[2]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 8'hA0};
      vt[3]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 8'hA2};
      for (int i = 4; i < 9; i++) vt[i] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00};
      vt[9]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA3};
      vt[10] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0};
      vt[11] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[12] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2};
      vt[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      vt[14] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA1};
      vt[15] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0};
      ready_after_cfg = 4'b0010; data_after_cfg = 8'hA1;
      ready_second    = 4'b0100; data_second    = 8'hA2;
`endif

      rst_n = 1'b0;
      bus.req_valid_i = '0; bus.tx_fifo_full_i = 1'b0;
      bus.tx_fifo_empty_i = 1'b1; bus.tx_idle_i = 1'b1;
      cfg_req = 1'b0; req_done = 1'b0;
      cfg_w = 2'b00; cfg_s = 2'b00; cfg_p = 2'b00;
      set_fixed_data();
      @(negedge clk);
      check("reset", mk('0, 0, 8'h00, 0, 0, 0, 2'b11, 2'b00, 2'b00));
      @(posedge clk); #3 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         cyc(vt[i].valid, vt[i].full, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("vec%0d", i),
               mk(vt[i].exp_ready, vt[i].exp_write, vt[i].exp_data, 0, 0, 0, 2'b11, 2'b00, 2'b00));
      end

      // Reconfiguration with a non-empty FIFO, then 3 cycles until req_done.
      cfg_w = 2'b00; cfg_s = 2'b01; cfg_p = 2'b01;
      cyc(4'b1111, 0, 0, 0, 1, 0);
      check("cfg_req blocks", mk('0, 0, 8'h00, 0, 0, 0, 2'b11, 2'b00, 2'b00));
      for (int i = 0; i < 3; i++) begin
         cyc(4'b1111, 0, 0, 0, 1, 0);
         check($sformatf("drain%0d", i), mk('0, 0, 8'h00, 0, 0, 1, 2'b11, 2'b00, 2'b00));
      end
      cyc(4'b1111, 0, 1, 1, 1, 0);
      check("drain empty", mk('0, 0, 8'h00, 0, 0, 1, 2'b11, 2'b00, 2'b00));
      for (int i = 0; i < 3; i++) begin
         cyc(4'b1111, 0, 1, 1, 1, 0);
         check($sformatf("config%0d", i), mk('0, 0, 8'h00, 1, 0, 1, 2'b00, 2'b01, 2'b01));
      end
      cyc(4'b1111, 0, 1, 1, 1, 1);
      check("req_done", mk('0, 0, 8'h00, 1, 0, 1, 2'b00, 2'b01, 2'b01));
      cyc(4'b1111, 0, 1, 1, 0, 0);
      check("cfg_done", mk(ready_after_cfg, 1, data_after_cfg, 0, 1, 0, 2'b00, 2'b01, 2'b01));
      cyc(4'b0000, 0, 1, 1, 0, 0);
      check("cfg_done pulse", mk('0, 0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01));

      // Reset in CONFIG; drain already satisfied so DRAIN lasts one cycle.
      cfg_w = 2'b01; cfg_s = 2'b10; cfg_p = 2'b10;
      cyc(4'b0000, 0, 1, 1, 1, 0);
      check("fast arb", mk('0, 0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 2'b01));
      cyc(4'b0000, 0, 1, 1, 1, 0);
      check("fast drain", mk('0, 0, 8'h00, 0, 0, 1, 2'b00, 2'b01, 2'b01));
      cyc(4'b0000, 0, 1, 1, 1, 0);
      check("fast config", mk('0, 0, 8'h00, 1, 0, 1, 2'b01, 2'b10, 2'b10));
      #1 rst_n = 1'b0;
      #1 check("reset in config", mk('0, 0, 8'h00, 0, 0, 0, 2'b11, 2'b00, 2'b00));
      cfg_req = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      cyc(4'b0101, 0, 1, 1, 0, 0);
      check("post reset 1", mk(4'b0001, 1, 8'hA0, 0, 0, 0, 2'b11, 2'b00, 2'b00));
      cyc(4'b0101, 0, 1, 1, 0, 0);
      check("post reset 2", mk(ready_second, 1, data_second, 0, 0, 0, 2'b11, 2'b00, 2'b00));

      // Randomized run against the model.
      @(negedge clk);
      rst_n = 1'b0; bus.req_valid_i = '0; cfg_req = 1'b0; req_done = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      model_reset();
      pend = '0;
      for (int i = 0; i < N; i++) pdata[i] = 8'h00;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!pend[IW'(i)] && ($urandom % 2 == 0)) begin
               pend[IW'(i)] = 1'b1;
               pdata[i] = 8'($urandom);
            end
            bus.req_data_i[IW'(i)] = pdata[i];
         end
         bus.req_valid_i     = pend;
         bus.tx_fifo_full_i  = ($urandom % 4 == 0);
         bus.tx_fifo_empty_i = ($urandom % 2 == 0);
         bus.tx_idle_i       = ($urandom % 4 != 0);
         if (!cfg_req) begin
            if ($urandom % 25 == 0) begin
               cfg_req = 1'b1;
               cfg_w = 2'($urandom); cfg_s = 2'($urandom); cfg_p = 2'($urandom);
            end
         end else if (m_done && ($urandom % 4 != 0)) begin
            cfg_req = 1'b0;
         end
         req_done = (m_phase == P_CFG) && ($urandom % 3 == 0);
         @(negedge clk);
         model_eval(e, acc);
         check($sformatf("rand%0d", c), e);
         if (acc >= 0) pend[IW'(acc)] = 1'b0;
         model_advance(acc);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/tx_write_arbiter.md
# tx_write_arbiter

Arbiter and sequencer in front of the UART `transmitter`. It shares the transmitter's single FIFO write port between `N_REQ` byte producers using valid/ready handshakes. It also sequences frame-format reconfiguration: block new writes, drain the TX path, run the `config_req_mst`/`req_done` handshake, then resume. It sits between the bus-side producers and the `transmitter` instance, on the same clock as `baud_rate_generator`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `PTR_W`, default `$clog2(N_REQ)`: width of the round-robin pointer; derived, do not override.

Ports:
- `clk_i`  in  1  system clock, 100 MHz.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  N_REQ  per-requester byte valid.
- `req_data_i`  in  N_REQ×8  per-requester byte, packed as `[N_REQ-1:0][7:0]`.
- `req_ready_o`  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero).
- `data_tx_o`  out  8  byte to the transmitter FIFO.
- `tx_fifo_write_o`  out  1  transmitter FIFO write strobe.
- `tx_fifo_full_i`  in  1  transmitter FIFO full.
- `tx_fifo_empty_i`  in  1  transmitter FIFO empty.
- `tx_idle_i`  in  1  transmitter not shifting a frame.
- `cfg_req_i`  in  1  level request for a format change; hold until `cfg_done_o`.
- `cfg_data_width_i`, `cfg_stop_bits_i`, `cfg_parity_i`  in  2 each  requested format.
- `config_req_mst_o`  out  1  configuration request to the transmitter.
- `req_done_i`  in  1  transmitter acknowledges the configuration.
- `data_width_o`, `stop_bits_number_o`, `parity_mode_o`  out  2 each  registered active format.
- `cfg_done_o`  out  1  one-cycle pulse when reconfiguration completes.
- `busy_cfg_o`  out  1  high in DRAIN or CONFIG.

## Operation
- FSM states: ARBITRATE (reset state), DRAIN, CONFIG.
- **ARBITRATE**
  - Grant goes to the first requester with `req_valid_i` set, searching from `rr_ptr` upward with wrap-around.
  - `req_ready_o[g]` = grant[g] & !`tx_fifo_full_i` & !`cfg_req_i`.
  - On accept (valid & ready):
    - `tx_fifo_write_o` = 1 and `data_tx_o` = `req_data_i[g]` in the same cycle (combinational).
    - `rr_ptr` <= (g+1) mod `N_REQ`.
  - With no accept, `rr_ptr` holds.
- **ARBITRATE → DRAIN** when `cfg_req_i` = 1.
  - At the transition, capture the three cfg inputs into shadow registers.
  - No grant is issued in that cycle.
- **DRAIN → CONFIG** when `tx_fifo_empty_i` & `tx_idle_i`.
  - If both are already true on entry, DRAIN still lasts exactly 1 cycle.
- **CONFIG**
  - `config_req_mst_o` = 1 (registered, set on entry).
  - Format outputs = shadow values, updated on entry.
  - On `req_done_i`:
    - drop `config_req_mst_o` next cycle;
    - pulse `cfg_done_o` for 1 cycle;
    - return to ARBITRATE.
- `req_ready_o` and `tx_fifo_write_o` are 0 in DRAIN and CONFIG.
- Producers keep `req_valid_i` and data stable until accepted; the block does not drop or buffer bytes.
- `cfg_req_i` still high when the FSM returns to ARBITRATE starts a new reconfiguration.

## Timing
- Reset values:
  - `req_ready_o` = 0, `tx_fifo_write_o` = 0, `data_tx_o` = 0.
  - `config_req_mst_o` = 0, `cfg_done_o` = 0, `busy_cfg_o` = 0.
  - `data_width_o` = 2'b11 (8 bits), `stop_bits_number_o` = 0, `parity_mode_o` = 0.
  - `rr_ptr` = 0, state ARBITRATE.
- Write latency is 0 cycles. Peak throughput is 1 byte/cycle while the FIFO is not full.
- `tx_fifo_full_i` high blocks the accept in the same cycle; no write is ever issued while full.
- Reconfiguration latency from `cfg_req_i` rising to `config_req_mst_o` = 1 is 2 cycles minimum (1 ARBITRATE + 1 DRAIN), plus the drain time.
- Reset asserted mid-DRAIN or mid-CONFIG: all outputs return to reset values asynchronously and the shadow registers are lost.

## Configuration
- `TX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, requester 0 highest; `rr_ptr` is removed and reads as constant 0.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then requesters 0 and 2 valid continuously:
  - accepts alternate 0,2,0,2 on consecutive cycles;
  - `tx_fifo_write_o` high every cycle;
  - `data_tx_o` matches the granted byte.
- All 4 requesters valid, `tx_fifo_full_i` = 1 for 5 cycles:
  - `req_ready_o` = 0 and no write for those 5 cycles;
  - on release, grant resumes at `rr_ptr`, with no skip or repeat.
- `cfg_req_i` with width 2'b00, stop 1, parity 2'b01 while FIFO non-empty:
  - `req_ready_o` = 0 from the same cycle;
  - `config_req_mst_o` rises 1 cycle after `tx_fifo_empty_i` & `tx_idle_i`;
  - `req_done_i` after 3 cycles → `cfg_done_o` pulse, outputs 00/1/01.
- Reset asserted during CONFIG:
  - `config_req_mst_o` = 0 immediately;
  - format outputs return to 11/0/00;
  - the FSM arbitrates normally after release.
- With `TX_ARB_FIXED_PRIO_EN`, requesters 1 and 3 valid: requester 1 is always granted until its `req_valid_i` drops.
